// File: rtl/vga_csr_ctrl_if.sv
// vga_csr_ctrl_if: native CSR bus between the AXI-Lite slave FSM and the VGA CSR bank.
//   write_en_i/addr_write_i/wdata_i  : one-cycle write strobe, word address, data
//   read_en_sync_i/addr_read_i       : one-cycle read strobe, word address
//   rdata_o                          : read data, valid the cycle after the read strobe
//   master modport drives strobes (slave FSM side), slave modport is the register bank.
interface vga_csr_ctrl_if #(
    parameter int NATIVE_ADDR_W = 4,
    parameter int DATA_W        = 32
);
    logic                     write_en_i;
    logic [NATIVE_ADDR_W-1:0] addr_write_i;
    logic [DATA_W-1:0]        wdata_i;
    logic                     read_en_sync_i;
    logic [NATIVE_ADDR_W-1:0] addr_read_i;
    logic [DATA_W-1:0]        rdata_o;

    modport master (
        output write_en_i, addr_write_i, wdata_i, read_en_sync_i, addr_read_i,
        input  rdata_o
    );

    modport slave (
        input  write_en_i, addr_write_i, wdata_i, read_en_sync_i, addr_read_i,
        output rdata_o
    );
endinterface

// File: rtl/vga_csr_ctrl.sv
// vga_csr_ctrl: CSR bank for the VGA timing generator with frame-aligned shadow commit.
//   clk_i, arst_n_i (async, active-low) : clock and reset
//   bus (vga_csr_ctrl_if.slave)         : native write/read strobes and read data
//   frame_start_i                       : first-pixel-of-frame pulse from the timing generator
//   enable_o                            : timing generator enable
//   h_active_o/v_active_o/h_total_o/v_total_o : live timing values
//   irq_o                               : registered frame interrupt level
//   Optional frame counter built when VGA_CSR_FRAME_CNT_EN is defined.
module vga_csr_ctrl #(
    parameter int NATIVE_ADDR_W = 4,
    parameter int DATA_W        = 32,
    parameter int TIMING_W      = 12
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    vga_csr_ctrl_if.slave       bus,
    input  logic                frame_start_i,
    output logic                enable_o,
    output logic [TIMING_W-1:0] h_active_o,
    output logic [TIMING_W-1:0] v_active_o,
    output logic [TIMING_W-1:0] h_total_o,
    output logic [TIMING_W-1:0] v_total_o,
    output logic                irq_o
);
    typedef enum logic {IDLE, PENDING} state_e;

    localparam logic [NATIVE_ADDR_W-1:0] A_CTRL   = 0;
    localparam logic [NATIVE_ADDR_W-1:0] A_HACT   = 1;
    localparam logic [NATIVE_ADDR_W-1:0] A_VACT   = 2;
    localparam logic [NATIVE_ADDR_W-1:0] A_HTOT   = 3;
    localparam logic [NATIVE_ADDR_W-1:0] A_VTOT   = 4;
    localparam logic [NATIVE_ADDR_W-1:0] A_STATUS = 5;
    localparam logic [NATIVE_ADDR_W-1:0] A_FCNT   = 6;

    // Slot 0..3 = H_ACTIVE, V_ACTIVE, H_TOTAL, V_TOTAL (640x480 @ 800x525)
    localparam logic [3:0][TIMING_W-1:0] RST_TIMING = {
        TIMING_W'(525), TIMING_W'(800), TIMING_W'(480), TIMING_W'(640)
    };

    state_e                    state_q, state_d;
    logic [3:0][TIMING_W-1:0]  shadow_q, shadow_d, live_q, live_d;
    logic                      enable_q, enable_d, irq_en_q, irq_en_d;
    logic                      apply_q, apply_d, frame_done_q, frame_done_d;
    logic                      irq_q, irq_d;
    logic [DATA_W-1:0]         rdata_q, rdata_d, rd_val, frame_cnt_rd;
    logic                      wr_timing, ctrl_wr, commit;
    logic [1:0]                wr_idx, rd_idx;
    logic                      unused_wdata;

    assign unused_wdata = ^bus.wdata_i[DATA_W-1:TIMING_W];

    always_comb begin
        wr_timing    = bus.write_en_i && bus.addr_write_i >= A_HACT && bus.addr_write_i <= A_VTOT;
        ctrl_wr      = bus.write_en_i && bus.addr_write_i == A_CTRL;
        wr_idx       = 2'(bus.addr_write_i - A_HACT);
        rd_idx       = 2'(bus.addr_read_i - A_HACT);
        // apply_q is the registered apply_now pulse, so apply commits one edge after the CTRL write
        commit       = state_q == PENDING && (frame_start_i || !enable_q || apply_q);
        shadow_d     = shadow_q;
        if (wr_timing)
            shadow_d[wr_idx] = bus.wdata_i[TIMING_W-1:0];
        // commit copies the pre-write shadow; a concurrent shadow write keeps us PENDING
        live_d       = commit ? shadow_q : live_q;
        state_d      = wr_timing ? PENDING : commit ? IDLE : state_q;
        enable_d     = ctrl_wr ? bus.wdata_i[0] : enable_q;
        irq_en_d     = ctrl_wr ? bus.wdata_i[1] : irq_en_q;
        apply_d      = ctrl_wr && bus.wdata_i[2];
        frame_done_d = frame_start_i || (frame_done_q &&
                       !(bus.write_en_i && bus.addr_write_i == A_STATUS && bus.wdata_i[0]));
        irq_d        = frame_done_q && irq_en_q;
        case (bus.addr_read_i)
            A_CTRL:                         rd_val = DATA_W'({irq_en_q, enable_q});
            A_HACT, A_VACT, A_HTOT, A_VTOT: rd_val = DATA_W'(shadow_q[rd_idx]);
            A_STATUS:                       rd_val = DATA_W'({state_q == PENDING, frame_done_q});
            A_FCNT:                         rd_val = frame_cnt_rd;
            default:                        rd_val = '0;
        endcase
        rdata_d      = bus.read_en_sync_i ? rd_val : rdata_q;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q      <= IDLE;
            shadow_q     <= RST_TIMING;
            live_q       <= RST_TIMING;
            enable_q     <= 1'b0;
            irq_en_q     <= 1'b0;
            apply_q      <= 1'b0;
            frame_done_q <= 1'b0;
            irq_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            live_q       <= live_d;
            enable_q     <= enable_d;
            irq_en_q     <= irq_en_d;
            apply_q      <= apply_d;
            frame_done_q <= frame_done_d;
            irq_q        <= irq_d;
            rdata_q      <= rdata_d;
        end
    end

`ifdef VGA_CSR_FRAME_CNT_EN
    logic [DATA_W-1:0] frame_cnt_q, frame_cnt_d;

    always_comb
        frame_cnt_d = (bus.write_en_i && bus.addr_write_i == A_FCNT) ? '0 :
                      (frame_start_i && enable_q) ? frame_cnt_q + DATA_W'(1) : frame_cnt_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)
            frame_cnt_q <= '0;
        else
            frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt_rd = frame_cnt_q;
`else
    assign frame_cnt_rd = '0;
`endif

    assign enable_o    = enable_q;
    assign h_active_o  = live_q[0];
    assign v_active_o  = live_q[1];
    assign h_total_o   = live_q[2];
    assign v_total_o   = live_q[3];
    assign irq_o       = irq_q;
    assign bus.rdata_o = rdata_q;
endmodule

// File: tb/tb_vga_csr_ctrl.sv
// tb_vga_csr_ctrl: directed table, random stimulus against a register-level model, async reset check.
module tb_vga_csr_ctrl;
    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic        frame_start_i;
    logic        enable_o, irq_o;
    logic [11:0] h_active_o, v_active_o, h_total_o, v_total_o;
    int          vectors = 0, miscompares = 0;

    vga_csr_ctrl_if #(.NATIVE_ADDR_W(4), .DATA_W(32)) bus ();

    vga_csr_ctrl #(.NATIVE_ADDR_W(4), .DATA_W(32), .TIMING_W(12)) dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .bus(bus), .frame_start_i(frame_start_i),
        .enable_o(enable_o), .h_active_o(h_active_o), .v_active_o(v_active_o),
        .h_total_o(h_total_o), .v_total_o(v_total_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef VGA_CSR_FRAME_CNT_EN
    localparam logic [31:0] CNT3 = 32'd3;
`else
    localparam logic [31:0] CNT3 = 32'd0;
`endif

    typedef struct {
        bit          we;
        logic [3:0]  wa;
        logic [31:0] wd;
        bit          re;
        logic [3:0]  ra;
        bit          fs;
        bit          chk_rd;
        logic [31:0] e_rd;
        logic [11:0] e_h, e_ht, e_vt;
        bit          e_irq, e_en;
    } vec_t;

    vec_t tbl[$];

    // Reference model: register contents as the programmer sees them.
    int unsigned m_sh[4], m_lv[4];
    bit          m_en, m_ie, m_ap, m_pend, m_fd, m_irq;
    logic [31:0] m_rd, m_cnt;

    function automatic vec_t row(bit we, logic [3:0] wa, logic [31:0] wd, bit re, logic [3:0] ra,
                                 bit fs, bit chk, logic [31:0] erd, logic [11:0] eh,
                                 logic [11:0] eht, logic [11:0] evt, bit eirq, bit een);
        vec_t r;
        r.we = we; r.wa = wa; r.wd = wd; r.re = re; r.ra = ra; r.fs = fs;
        r.chk_rd = chk; r.e_rd = erd; r.e_h = eh; r.e_ht = eht; r.e_vt = evt;
        r.e_irq = eirq; r.e_en = een;
        return r;
    endfunction

    task automatic m_reset();
        m_sh = '{640, 480, 800, 525};
        m_lv = '{640, 480, 800, 525};
        {m_en, m_ie, m_ap, m_pend, m_fd, m_irq} = '0;
        m_rd = 0;
        m_cnt = 0;
    endtask

    function automatic logic [31:0] m_read(logic [3:0] a);
        if (a == 0) return {30'd0, m_ie, m_en};
        if (a >= 1 && a <= 4) return m_sh[a-1];
        if (a == 5) return {30'd0, m_pend, m_fd};
`ifdef VGA_CSR_FRAME_CNT_EN
        if (a == 6) return m_cnt;
`endif
        return 0;
    endfunction

    task automatic m_edge(bit we, logic [3:0] wa, logic [31:0] wd, bit re, logic [3:0] ra, bit fs);
        logic [31:0] rv;
        bit commit;
        rv = m_read(ra);
        commit = m_pend && (fs || !m_en || m_ap);
        m_irq = m_fd && m_ie;
        if (commit) m_lv = m_sh;
        if (re) m_rd = rv;
`ifdef VGA_CSR_FRAME_CNT_EN
        if (we && wa == 6) m_cnt = 0;
        else if (fs && m_en) m_cnt = m_cnt + 1;
`endif
        m_fd = fs || (m_fd && !(we && wa == 5 && wd[0]));
        if (we && wa >= 1 && wa <= 4) begin
            m_sh[wa-1] = wd % 4096;
            m_pend = 1;
        end else if (commit) m_pend = 0;
        if (we && wa == 0) {m_ap, m_ie, m_en} = wd[2:0];
        else m_ap = 0;
    endtask

    task automatic check_model(string tag);
        vectors++;
        if (enable_o !== m_en || irq_o !== m_irq || h_active_o !== 12'(m_lv[0]) ||
            v_active_o !== 12'(m_lv[1]) || h_total_o !== 12'(m_lv[2]) ||
            v_total_o !== 12'(m_lv[3]) || bus.rdata_o !== m_rd) begin
            miscompares++;
            $display("FAIL %s: got en=%0d irq=%0d h=%0d v=%0d ht=%0d vt=%0d rd=%h, want en=%0d irq=%0d h=%0d v=%0d ht=%0d vt=%0d rd=%h",
                     tag, enable_o, irq_o, h_active_o, v_active_o, h_total_o, v_total_o, bus.rdata_o,
                     m_en, m_irq, m_lv[0], m_lv[1], m_lv[2], m_lv[3], m_rd);
        end
    endtask

    task automatic check_reset(string tag);
        vectors++;
        if (enable_o !== 0 || irq_o !== 0 || h_active_o !== 640 || v_active_o !== 480 ||
            h_total_o !== 800 || v_total_o !== 525 || bus.rdata_o !== 0) begin
            miscompares++;
            $display("FAIL %s: got en=%0d irq=%0d h=%0d v=%0d ht=%0d vt=%0d rd=%h, want reset values 0 0 640 480 800 525 0",
                     tag, enable_o, irq_o, h_active_o, v_active_o, h_total_o, v_total_o, bus.rdata_o);
        end
    endtask

    task automatic apply(bit we, logic [3:0] wa, logic [31:0] wd, bit re, logic [3:0] ra, bit fs, string tag);
        bus.write_en_i = we; bus.addr_write_i = wa; bus.wdata_i = wd;
        bus.read_en_sync_i = re; bus.addr_read_i = ra; frame_start_i = fs;
        @(posedge clk_i);
        m_edge(we, wa, wd, re, ra, fs);
        #1;
        check_model(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] wa;
        logic [31:0] wd;
        arst_n_i = 0; frame_start_i = 0;
        bus.write_en_i = 0; bus.addr_write_i = 0; bus.wdata_i = 0;
        bus.read_en_sync_i = 0; bus.addr_read_i = 0;
        m_reset();
        //               we wa  wd        re ra  fs chk erd     h      ht   vt  irq en
        tbl.push_back(row(0, 0, 0,        1, 0,  0, 1, 0,      640,   800, 525, 0, 0));
        tbl.push_back(row(0, 0, 0,        1, 1,  0, 1, 640,    640,   800, 525, 0, 0));
        tbl.push_back(row(0, 0, 0,        1, 2,  0, 1, 480,    640,   800, 525, 0, 0));
        tbl.push_back(row(0, 0, 0,        1, 3,  0, 1, 800,    640,   800, 525, 0, 0));
        tbl.push_back(row(0, 0, 0,        1, 4,  0, 1, 525,    640,   800, 525, 0, 0));
        tbl.push_back(row(0, 0, 0,        1, 5,  0, 1, 0,      640,   800, 525, 0, 0));
        tbl.push_back(row(0, 0, 0,        1, 6,  0, 1, 0,      640,   800, 525, 0, 0));
        tbl.push_back(row(0, 0, 0,        1, 15, 0, 1, 0,      640,   800, 525, 0, 0));
        tbl.push_back(row(1, 0, 1,        0, 0,  0, 0, 0,      640,   800, 525, 0, 1));
        tbl.push_back(row(1, 1, 'h50320,  0, 0,  0, 0, 0,      640,   800, 525, 0, 1));
        tbl.push_back(row(0, 0, 0,        1, 1,  0, 1, 'h320,  640,   800, 525, 0, 1));
        tbl.push_back(row(0, 0, 0,        1, 5,  0, 1, 2,      640,   800, 525, 0, 1));
        tbl.push_back(row(0, 0, 0,        0, 0,  1, 0, 0,      'h320, 800, 525, 0, 1));
        tbl.push_back(row(0, 0, 0,        1, 5,  0, 1, 1,      'h320, 800, 525, 0, 1));
        tbl.push_back(row(1, 0, 0,        0, 0,  0, 0, 0,      'h320, 800, 525, 0, 0));
        tbl.push_back(row(1, 4, 600,      0, 0,  0, 0, 0,      'h320, 800, 525, 0, 0));
        tbl.push_back(row(0, 0, 0,        0, 0,  0, 0, 0,      'h320, 800, 600, 0, 0));
        tbl.push_back(row(0, 0, 0,        1, 5,  0, 1, 1,      'h320, 800, 600, 0, 0));
        tbl.push_back(row(1, 5, 1,        0, 0,  0, 0, 0,      'h320, 800, 600, 0, 0));
        tbl.push_back(row(1, 0, 3,        0, 0,  0, 0, 0,      'h320, 800, 600, 0, 1));
        tbl.push_back(row(0, 0, 0,        0, 0,  1, 0, 0,      'h320, 800, 600, 0, 1));
        tbl.push_back(row(0, 0, 0,        0, 0,  0, 0, 0,      'h320, 800, 600, 1, 1));
        tbl.push_back(row(1, 5, 1,        0, 0,  1, 0, 0,      'h320, 800, 600, 1, 1));
        tbl.push_back(row(0, 0, 0,        0, 0,  0, 0, 0,      'h320, 800, 600, 1, 1));
        tbl.push_back(row(1, 5, 1,        0, 0,  0, 0, 0,      'h320, 800, 600, 1, 1));
        tbl.push_back(row(0, 0, 0,        0, 0,  0, 0, 0,      'h320, 800, 600, 0, 1));
        tbl.push_back(row(1, 3, 850,      0, 0,  0, 0, 0,      'h320, 800, 600, 0, 1));
        tbl.push_back(row(1, 3, 900,      0, 0,  1, 0, 0,      'h320, 850, 600, 0, 1));
        tbl.push_back(row(0, 0, 0,        1, 5,  0, 1, 3,      'h320, 850, 600, 1, 1));
        tbl.push_back(row(0, 0, 0,        0, 0,  1, 0, 0,      'h320, 900, 600, 1, 1));
        tbl.push_back(row(0, 0, 0,        1, 3,  0, 1, 900,    'h320, 900, 600, 1, 1));
        tbl.push_back(row(1, 6, 0,        0, 0,  0, 0, 0,      'h320, 900, 600, 1, 1));
        tbl.push_back(row(0, 0, 0,        0, 0,  1, 0, 0,      'h320, 900, 600, 1, 1));
        tbl.push_back(row(0, 0, 0,        0, 0,  1, 0, 0,      'h320, 900, 600, 1, 1));
        tbl.push_back(row(0, 0, 0,        0, 0,  1, 0, 0,      'h320, 900, 600, 1, 1));
        tbl.push_back(row(0, 0, 0,        1, 6,  0, 1, CNT3,   'h320, 900, 600, 1, 1));
        tbl.push_back(row(1, 6, 'h1234,   0, 0,  0, 0, 0,      'h320, 900, 600, 1, 1));
        tbl.push_back(row(0, 0, 0,        1, 6,  0, 1, 0,      'h320, 900, 600, 1, 1));
        tbl.push_back(row(1, 1, 'h111,    0, 0,  0, 0, 0,      'h320, 900, 600, 1, 1));
        tbl.push_back(row(1, 0, 7,        0, 0,  0, 0, 0,      'h320, 900, 600, 1, 1));
        tbl.push_back(row(0, 0, 0,        0, 0,  0, 0, 0,      'h111, 900, 600, 1, 1));
        tbl.push_back(row(0, 0, 0,        1, 0,  0, 1, 3,      'h111, 900, 600, 1, 1));
        tbl.push_back(row(0, 0, 0,        1, 1,  0, 1, 'h111,  'h111, 900, 600, 1, 1));
        tbl.push_back(row(1, 9, 'hffff,   0, 0,  0, 0, 0,      'h111, 900, 600, 1, 1));
        tbl.push_back(row(0, 0, 0,        1, 9,  0, 1, 0,      'h111, 900, 600, 1, 1));
        tbl.push_back(row(1, 1, 'h222,    1, 1,  0, 1, 'h111,  'h111, 900, 600, 1, 1));
        tbl.push_back(row(0, 0, 0,        1, 1,  0, 1, 'h222,  'h111, 900, 600, 1, 1));
        tbl.push_back(row(1, 0, 1,        0, 0,  0, 0, 0,      'h111, 900, 600, 1, 1));
        tbl.push_back(row(0, 0, 0,        0, 0,  0, 0, 0,      'h111, 900, 600, 0, 1));

        repeat (2) @(posedge clk_i);
        #1;
        check_reset("reset_state");
        @(negedge clk_i);
        arst_n_i = 1;

        foreach (tbl[i]) begin
            apply(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].fs, $sformatf("model_tbl[%0d]", i));
            vectors++;
            if ((tbl[i].chk_rd && bus.rdata_o !== tbl[i].e_rd) || h_active_o !== tbl[i].e_h ||
                h_total_o !== tbl[i].e_ht || v_total_o !== tbl[i].e_vt ||
                irq_o !== tbl[i].e_irq || enable_o !== tbl[i].e_en) begin
                miscompares++;
                $display("FAIL tbl[%0d]: got rd=%h h=%0d ht=%0d vt=%0d irq=%0d en=%0d, want rd=%h(chk=%0d) h=%0d ht=%0d vt=%0d irq=%0d en=%0d",
                         i, bus.rdata_o, h_active_o, h_total_o, v_total_o, irq_o, enable_o,
                         tbl[i].e_rd, tbl[i].chk_rd, tbl[i].e_h, tbl[i].e_ht, tbl[i].e_vt,
                         tbl[i].e_irq, tbl[i].e_en);
            end
        end

        for (int n = 0; n < 600; n++) begin
            wa = 4'($urandom_range(0, 8));
            if (wa == 8) wa = 15;
            wd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            apply($urandom_range(0, 2) == 0, wa, wd, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), $urandom_range(0, 5) == 0, $sformatf("rand[%0d]", n));
        end

        bus.write_en_i = 0; frame_start_i = 0;
        bus.read_en_sync_i = 1; bus.addr_read_i = 1;
        @(negedge clk_i);
        arst_n_i = 0;
        #1;
        check_reset("reset_mid_read");
        m_reset();
        bus.read_en_sync_i = 0;
        @(negedge clk_i);
        arst_n_i = 1;
        apply(0, 0, 0, 0, 0, 0, "post_reset_idle");
        apply(0, 0, 0, 1, 1, 0, "post_reset_hact");
        apply(0, 0, 0, 1, 5, 0, "post_reset_status");
        apply(0, 0, 0, 1, 6, 0, "post_reset_fcnt");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
